// File: rtl/bytewrite_ram_sp_rf_core.sv
// Single-port RAM with per-column byte enables and read-first output.
// The read data register is the only state cleared by reset.
module bytewrite_ram_sp_rf_core #(
  parameter  int NUM_COL    = 4,
  parameter  int COL_WIDTH  = 8,
  parameter  int ADDR_WIDTH = 10,
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NUM_COL-1:0]    we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] ram_q [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;
  logic [NUM_COL-1:0]    wr_col_s;

  // Column write strobes; a held reset or disabled port suppresses all writes.
  always_comb begin
    wr_col_s = {NUM_COL{1'b0}};
    if (ena && rst_n) begin
      wr_col_s = we;
    end else begin
      wr_col_s = {NUM_COL{1'b0}};
    end
  end

  // Next read data: the array value before this edge's write, held when disabled.
  always_comb begin
    dout_d = dout_q;
    if (ena) begin
      dout_d = ram_q[addr];
    end else begin
      dout_d = dout_q;
    end
  end

  // Memory array, kept free of reset so it maps onto byte-enabled block RAM.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_COL; k++) begin
      if (wr_col_s[k]) begin
        ram_q[addr][k*COL_WIDTH +: COL_WIDTH] <= din[k*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // Output data register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= {DATA_WIDTH{1'b0}};
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_bytewrite_ram_sp_rf_core.sv
// Randomised and directed checks of the byte-write RAM against an array model
// that tracks which byte columns have been written.
module tb_bytewrite_ram_sp_rf_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [3:0]  we = 4'b0000;
  logic [9:0]  addr = 10'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;

  int total = 0;
  int bad = 0;

  logic [31:0] mdl [1024];
  logic [3:0]  vld [1024];
  logic [31:0] exp_d = 32'd0;
  logic [31:0] exp_m = 32'hFFFF_FFFF;

  bytewrite_ram_sp_rf_core dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = {8{m[k]}};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive, update the model at the edge, compare on the falling edge.
  task automatic cycle(input string tag, input logic e, input logic [3:0] w,
                       input logic [9:0] a, input logic [31:0] d);
    ena = e; we = w; addr = a; din = d;
    @(posedge clk);
    if (rst_n) begin
      if (e) begin
        exp_d = mdl[a];
        exp_m = expand(vld[a]);
        for (int k = 0; k < 4; k++) begin
          if (w[k]) begin
            mdl[a][k*8 +: 8] = d[k*8 +: 8];
            vld[a][k] = 1'b1;
          end
        end
      end
    end else begin
      exp_d = 32'd0;
      exp_m = 32'hFFFF_FFFF;
    end
    @(negedge clk);
    if (exp_m != 32'd0) check(tag, dout & exp_m, exp_d & exp_m);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mdl[i] = 32'd0;
      vld[i] = 4'b0000;
    end

    // reset held with live traffic: dout stays zero, nothing is written
    rst_n = 1'b0;
    #1 check("reset_async", dout, 32'd0);
    for (int i = 0; i < 8; i++)
      cycle("reset_hold", 1'b1, 4'($urandom), 10'($urandom), $urandom);
    rst_n = 1'b1;

    // two full write sweeps; the second observes the first's data as old data
    for (int i = 0; i < 1024; i++) cycle("wsweep1", 1'b1, 4'b1111, 10'(i), $urandom);
    for (int i = 0; i < 1024; i++) cycle("wsweep2", 1'b1, 4'b1111, 10'(i), $urandom);
    for (int i = 0; i < 1024; i++) cycle("rsweep", 1'b1, 4'b0000, 10'(i), $urandom);

    // byte enables
    cycle("be_w1", 1'b1, 4'b1111, 10'd5, 32'hAABBCCDD);
    cycle("be_w2", 1'b1, 4'b0101, 10'd5, 32'h11223344);
    check("be_w2_old", dout, 32'hAABBCCDD);
    cycle("be_rd", 1'b1, 4'b0000, 10'd5, $urandom);
    check("be_merge", dout, 32'hAA22CC44);

    // disabled port: no writes, dout holds
    for (int i = 0; i < 1024; i++) begin
      cycle("dis_sweep", 1'b0, 4'b1011, 10'(i), $urandom);
      if (i == 1023) check("dis_hold", dout, 32'hAA22CC44);
    end
    for (int i = 0; i < 1024; i++) cycle("dis_rsweep", 1'b1, 4'b0000, 10'(i), $urandom);

    // read-first on the same address
    cycle("rf_pre", 1'b1, 4'b1111, 10'd7, 32'h12345678);
    cycle("rf_wr", 1'b1, 4'b1111, 10'd7, 32'hCAFEF00D);
    check("rf_old", dout, 32'h12345678);
    cycle("rf_rd", 1'b1, 4'b0000, 10'd7, 32'd0);
    check("rf_new", dout, 32'hCAFEF00D);

    // reset pulsed between edges during a read sweep
    for (int i = 0; i < 256; i++) begin
      cycle("mid_rsweep", 1'b1, 4'b0000, 10'(i), $urandom);
      if (i == 100) begin
        #1 rst_n = 1'b0;
        #1 check("mid_reset", dout, 32'd0);
        #1 rst_n = 1'b1;
        exp_d = 32'd0;
        exp_m = 32'hFFFF_FFFF;
      end
    end

    // write on the edge right after reset release completes
    rst_n = 1'b0;
    cycle("rel_hold", 1'b1, 4'b1111, 10'd9, 32'h0BAD_0BAD);
    rst_n = 1'b1;
    cycle("rel_wr", 1'b1, 4'b1111, 10'd9, 32'h600D_F00D);
    cycle("rel_rd", 1'b1, 4'b0000, 10'd9, 32'd0);
    check("rel_data", dout, 32'h600D_F00D);

    // random mixed traffic over a narrow address window to force collisions
    for (int i = 0; i < 3000; i++)
      cycle("random", ($urandom_range(0, 3) != 0), 4'($urandom),
            10'($urandom_range(0, 15)), $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bytewrite_ram_sp_rf_core.md
Name: bytewrite_ram_sp_rf_core

Overview:
- Single-port synchronous RAM with per-byte write enables and read-first (old data) output behaviour.
- Default size is 1024 x 32 bits, organised as 4 byte columns.
- Used as a generic on-chip buffer; maps onto block RAM with byte-enable.
- The output data register has an asynchronous active-low reset.

Parameters:
- NUM_COL, 4, number of byte-write columns.
- COL_WIDTH, 8, bits per column.
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, NUM_COL*COL_WIDTH (32), word width; derived, not overridden independently.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset; clears the dout register only.
- ena  input  1  port enable; when low, no read and no write occur.
- we  input  NUM_COL  per-column write enable; we[k] controls din/ram bits [k*COL_WIDTH +: COL_WIDTH].
- addr  input  ADDR_WIDTH  word address.
- din  input  DATA_WIDTH  write data.
- dout  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset:
  - rst_n low asynchronously forces dout = 0 and holds it while low.
  - Memory array contents are not affected by reset.
  - Release is synchronous-safe: the first active edge after rst_n rises behaves normally.
- Initial state: memory contents are undefined until written. The bench must only check locations it has written.
- On each rising clk edge with rst_n high and ena = 1:
  - dout <= ram[addr] as the value before this edge's write (read-first).
  - Independently, for each k with we[k] = 1, the corresponding column of ram[addr] is written with the matching column of din.
  - Columns with we[k] = 0 keep their previous value.
- Read latency is 1 cycle: dout reflects the address presented at the previous rising edge.
- A write to address A followed by a read of A on the next edge returns the new data.
- The same-edge read of A returns the old data, even for columns being written.
- ena = 0: no memory update regardless of we; dout holds its previous value.
- we = 0 with ena = 1: pure read.
- Any we pattern is legal, including partial patterns such as 4'b1011 and all-ones.
- Addresses cover the full 0..2**ADDR_WIDTH-1 range; there is no wrap logic beyond natural width.
- Reset asserted mid-operation: dout clears immediately. A write on the same edge as reset release is allowed to complete.
- There are no X-propagation requirements beyond standard simulation semantics.

Test Plan:
- Reset: hold rst_n = 0 with ena = 1 and random inputs -> dout = 0x00000000 throughout.
- Full write sweep: ena = 1, we = 4'b1111, addr 0..1023, din random -> dout each cycle equals the prior content of that address (old data), never the din being written. Then a read sweep with we = 0, addr 0..1023 -> dout = the value written at addr-1 cycle, latency 1.
- Byte enables:
  - Write 0xAABBCCDD to addr 5 with we = 4'b1111.
  - Then write 0x11223344 with we = 4'b0101.
  - Then read addr 5 -> 0xAA22CC44.
- Disabled port: ena = 0, we = 4'b1011, sweep addresses with random din -> dout holds its last value. A subsequent ena = 1 read sweep -> contents unchanged from the prior sweep.
- Read-first on the same address:
  - addr 7 holds 0x12345678.
  - Write 0xCAFEF00D to addr 7 with we = 4'b1111 -> dout = 0x12345678 that cycle.
  - The next read of addr 7 -> 0xCAFEF00D.
- Reset mid-traffic: pulse rst_n low between clock edges during a read sweep -> dout = 0 immediately. After release, the next read returns the correct memory data (memory preserved).
